// File: rtl/rx_text_assembler_if.sv
// Byte-strobe input and published-text output bundle between the UART
// receiver, the text assembler and the downstream echo/command stage.
interface rx_text_assembler_if #(
  parameter int unsigned TEXT_BYTES = 32
);
  logic [7:0]              rx_byte;
  logic                    rx_byte_valid;
  logic [TEXT_BYTES*8-1:0] rx_text_bytes;
  logic [7:0]              rx_text_size;
  logic                    rx_is_text_ready;
  logic                    rx_text_terminated;

  modport master (
    output rx_byte, rx_byte_valid,
    input  rx_text_bytes, rx_text_size, rx_is_text_ready, rx_text_terminated
  );

  modport slave (
    input  rx_byte, rx_byte_valid,
    output rx_text_bytes, rx_text_size, rx_is_text_ready, rx_text_terminated
  );
endinterface

// File: rtl/rx_text_assembler.sv
// Collects UART bytes into a line buffer with backspace editing and publishes
// the text on CR/LF, buffer full or idle timeout.
module rx_text_assembler #(
  parameter int unsigned TEXT_BYTES     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  rx_text_assembler_if.slave bus
);
  localparam int unsigned CW = $clog2(TEXT_BYTES + 1);
  localparam int unsigned IW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] FULL_C   = CW'(TEXT_BYTES);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [IW-1:0] IDLE_SAT = IW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDLE_ONE = IW'(1);
  localparam logic [7:0]    CR_C     = 8'h0D;
  localparam logic [7:0]    LF_C     = 8'h0A;
  localparam logic [7:0]    BS_C     = 8'h08;

  logic [TEXT_BYTES*8-1:0] buf_r, buf_s, text_r;
  logic [CW-1:0]           count_r, count_s;
  logic [IW-1:0]           idle_r, idle_s;
  logic [7:0]              size_r;
  logic                    ready_r, term_r;
  logic                    done_s, term_s;

  // Next working-buffer contents and completion detection for this cycle
  always_comb begin
    buf_s   = buf_r;
    count_s = count_r;
    idle_s  = idle_r;
    done_s  = 1'b0;
    term_s  = 1'b0;
    if (bus.rx_byte_valid) begin
      // Any strobe, even an ignored one, restarts the idle window.
      idle_s = '0;
      case (bus.rx_byte)
        CR_C, LF_C: begin
          if (count_r != '0) begin
            done_s = 1'b1;
            term_s = 1'b1;
          end else begin
            done_s = 1'b0;
          end
        end
        BS_C: begin
          if (count_r != '0) begin
            count_s = count_r - ONE_C;
            buf_s[{count_s, 3'b000} +: 8] = 8'h00;
          end else begin
            count_s = count_r;
          end
        end
        default: begin
          buf_s[{count_r, 3'b000} +: 8] = bus.rx_byte;
          count_s = count_r + ONE_C;
          if (count_s == FULL_C) begin
            done_s = 1'b1;
          end else begin
            done_s = 1'b0;
          end
        end
      endcase
    end else if (count_r == '0) begin
      idle_s = '0;
    end else if (idle_r != IDLE_SAT) begin
      // Flush on the cycle the counter would reach the limit; a zero limit never counts.
      idle_s = idle_r + IDLE_ONE;
      if (idle_s == IDLE_SAT) begin
        done_s = 1'b1;
      end else begin
        done_s = 1'b0;
      end
    end else begin
      idle_s = idle_r;
    end
  end

  // Working state and published-text registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r   <= '0;
      count_r <= '0;
      idle_r  <= '0;
      text_r  <= '0;
      size_r  <= 8'd0;
      ready_r <= 1'b0;
      term_r  <= 1'b0;
    end else begin
      ready_r <= done_s;
      if (done_s) begin
        text_r  <= buf_s;
        size_r  <= 8'(count_s);
        term_r  <= term_s;
        buf_r   <= '0;
        count_r <= '0;
        idle_r  <= '0;
      end else begin
        buf_r   <= buf_s;
        count_r <= count_s;
        idle_r  <= idle_s;
      end
    end
  end

  assign bus.rx_text_bytes      = text_r;
  assign bus.rx_text_size       = size_r;
  assign bus.rx_is_text_ready   = ready_r;
  assign bus.rx_text_terminated = term_r;
endmodule

// File: tb/tb_rx_text_assembler.sv
// Directed bench for rx_text_assembler: a queue-based line model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_rx_text_assembler;
  localparam int TB_BYTES = 32;
  localparam int TB_TO    = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  rx_text_assembler_if #(.TEXT_BYTES(TB_BYTES)) bus ();

  rx_text_assembler #(.TEXT_BYTES(TB_BYTES), .TIMEOUT_CYCLES(TB_TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: the text is simply the queue of kept characters; quiet counts strobe-free clocks.
  logic [7:0]   mq[$];
  int           quiet     = 0;
  logic [255:0] exp_bytes = '0;
  logic [7:0]   exp_size  = 8'd0;
  logic         exp_ready = 1'b0;
  logic         exp_term  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      quiet = 0; exp_bytes = '0; exp_size = 8'd0; exp_ready = 1'b0; exp_term = 1'b0;
    end else begin
      bit done, term;
      done = 1'b0; term = 1'b0; exp_ready = 1'b0;
      if (bus.rx_byte_valid) begin
        quiet = 0;
        if (bus.rx_byte == 8'h0D || bus.rx_byte == 8'h0A) begin
          if (mq.size() > 0) begin done = 1'b1; term = 1'b1; end
        end else if (bus.rx_byte == 8'h08) begin
          if (mq.size() > 0) void'(mq.pop_back());
        end else begin
          mq.push_back(bus.rx_byte);
          if (mq.size() == TB_BYTES) done = 1'b1;
        end
      end else begin
        quiet++;
        if (quiet == TB_TO && mq.size() > 0) done = 1'b1;
      end
      if (done) begin
        exp_bytes = '0;
        foreach (mq[i]) exp_bytes[8*i +: 8] = mq[i];
        exp_size  = 8'(mq.size());
        exp_term  = term;
        exp_ready = 1'b1;
        mq.delete();
      end
    end
  end

  int pulses    = 0;
  int last_puls = -1;

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("ready", 256'(bus.rx_is_text_ready), 256'(exp_ready));
      check("bytes", bus.rx_text_bytes, exp_bytes);
      check("size",  256'(bus.rx_text_size), 256'(exp_size));
      check("term",  256'(bus.rx_text_terminated), 256'(exp_term));
      if (bus.rx_is_text_ready) begin
        pulses++;
        last_puls = cyc;
      end
    end
  end

  int strobe_cyc = 0;

  task automatic send(input logic [7:0] b);
    bus.rx_byte = b; bus.rx_byte_valid = 1'b1;
    @(posedge clk); #1;
    strobe_cyc = cyc;
    bus.rx_byte_valid = 1'b0; bus.rx_byte = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    bus.rx_byte = 8'h00; bus.rx_byte_valid = 1'b0;
    idle(3);
    check("reset_bytes", bus.rx_text_bytes, 256'h0);
    check("reset_size",  256'(bus.rx_text_size), 256'h0);
    rst_n = 1'b1;
    idle(2);

    // "hi" CR with gaps
    p0 = pulses;
    send(8'h68); idle(10); send(8'h69); idle(10); send(8'h0D);
    idle(1);
    check("hi_pulses",  256'(pulses - p0), 256'd1);
    check("hi_latency", 256'(last_puls), 256'(strobe_cyc));
    check("hi_bytes",   bus.rx_text_bytes, 256'h6968);
    check("hi_size",    256'(bus.rx_text_size), 256'd2);
    check("hi_term",    256'(bus.rx_text_terminated), 256'd1);

    // CR LF yields one text
    p0 = pulses;
    send(8'h61); send(8'h62); send(8'h0D); send(8'h0A); idle(3);
    check("crlf_pulses", 256'(pulses - p0), 256'd1);
    check("crlf_bytes",  bus.rx_text_bytes, 256'h6261);

    // Full buffer, then back-to-back byte into the fresh buffer
    p0 = pulses;
    for (int i = 0; i < TB_BYTES; i++) send(8'(8'h41 + i));
    check("full_ready", 256'(bus.rx_is_text_ready), 256'd1);
    check("full_size",  256'(bus.rx_text_size), 256'd32);
    check("full_top",   256'(bus.rx_text_bytes[255:248]), 256'h60);
    check("full_low",   256'(bus.rx_text_bytes[7:0]), 256'h41);
    check("full_term",  256'(bus.rx_text_terminated), 256'd0);
    send(8'h58); send(8'h0D); idle(2);
    check("full_pulses", 256'(pulses - p0), 256'd2);
    check("x_size",      256'(bus.rx_text_size), 256'd1);
    check("x_bytes",     bus.rx_text_bytes, 256'h58);

    // Backspace editing, including one on an empty buffer
    p0 = pulses;
    send(8'h08); idle(2);
    check("bs_empty_pulses", 256'(pulses - p0), 256'd0);
    send(8'h61); send(8'h62); send(8'h08); send(8'h63); send(8'h0D); idle(2);
    check("bs_size",  256'(bus.rx_text_size), 256'd2);
    check("bs_bytes", bus.rx_text_bytes, 256'h6361);

    // Idle timeout flush: ready appears 20 edges after the strobe's sampling edge
    p0 = pulses;
    send(8'h7A); idle(TB_TO + 3);
    check("to_pulses",  256'(pulses - p0), 256'd1);
    check("to_latency", 256'(last_puls - strobe_cyc), 256'(TB_TO));
    check("to_size",    256'(bus.rx_text_size), 256'd1);
    check("to_term",    256'(bus.rx_text_terminated), 256'd0);

    // Strobe landing on the expiry cycle wins
    p0 = pulses;
    send(8'h7A); idle(TB_TO - 1); send(8'h79); idle(3);
    check("race_nopulse", 256'(pulses - p0), 256'd0);
    send(8'h0D); idle(2);
    check("race_bytes", bus.rx_text_bytes, 256'h797A);
    check("race_term",  256'(bus.rx_text_terminated), 256'd1);

    // Reset mid-text discards the partial text
    p0 = pulses;
    send(8'h71); send(8'h72);
    rst_n = 1'b0; idle(2); rst_n = 1'b1; idle(1);
    send(8'h0D); idle(TB_TO + 3);
    check("rst_pulses", 256'(pulses - p0), 256'd0);
    check("rst_bytes",  bus.rx_text_bytes, 256'h0);
    check("rst_size",   256'(bus.rx_text_size), 256'd0);
    check("rst_term",   256'(bus.rx_text_terminated), 256'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
